// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
//   Symbol codes on the 2-bit bus between the key decoder and the Morse letter
//   FSM, plus the decoder's state encoding. The letter FSM imports the same
//   symbol constants so both sides agree on the code points.
// -----------------------------------------------------------------------------
package morse_pkg;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_SEND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_GAP     = 2'd2
  } morse_state_t;

endpackage

// File: rtl/morse_debouncer.sv
// -----------------------------------------------------------------------------
// morse_debouncer
//   Two-flop synchroniser followed by a stability counter. The debounced level
//   only follows the synchronised key after DEBOUNCE_CYCLES consecutive cycles
//   of disagreement, so the edge-to-level latency is 2 + DEBOUNCE_CYCLES.
// Ports
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   raw    in  1  raw key, asynchronous to clk
//   level  out 1  debounced level, registered
// -----------------------------------------------------------------------------
module morse_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any cycle of agreement restarts the count, so a glitch shorter than
  // DEBOUNCE_CYCLES never reaches the level register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt >= C_LAST) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign level = r_level;

endmodule

// File: rtl/morse_key_decoder.sv
// -----------------------------------------------------------------------------
// morse_key_decoder
//   Front end for the Morse letter FSM: debounces the telegraph key, times each
//   press and each gap, and emits one-cycle symbol codes (dot, dash, send).
//   The bus sits at SYM_NONE outside those pulses.
// Ports
//   clk          in  1  system clock
//   rst_n        in  1  asynchronous active-low reset
//   key_in       in  1  raw key, 1 = pressed
//   inputSignal  out 2  symbol code, registered one-cycle pulses
//   key_db       out 1  debounced key level
//   busy         out 1  letter in progress (state != IDLE)
//   overflow     out 1  sticky, a symbol was dropped; cleared with send
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no letter in progress, waiting for the first press
// ST_PRESSED | key held, dur_cnt timing the press
// ST_GAP     | key released, gap_cnt timing toward letter end
// -----------------------------------------------------------------------------
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int DASH_MIN_CYCLES   = 2000,
  parameter int LETTER_GAP_CYCLES = 6000,
  parameter int MAX_ELEMS         = 4,
  parameter int CNT_W             = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic [1:0] inputSignal,
  output logic       key_db,
  output logic       busy,
  output logic       overflow
);

  localparam int EW = $clog2(MAX_ELEMS + 1);

  localparam logic [CNT_W-1:0] C_DASH     = CNT_W'(DASH_MIN_CYCLES);
  localparam logic [CNT_W-1:0] C_GAP_LAST = CNT_W'(LETTER_GAP_CYCLES - 1);
  localparam logic [EW-1:0]    C_MAX      = EW'(MAX_ELEMS);

  logic             w_key_db;
  morse_state_t     r_state;
  logic [CNT_W-1:0] r_dur;
  logic [CNT_W-1:0] r_gap;
  logic [EW-1:0]    r_elem;
  logic [1:0]       r_sym;
  logic             r_ovf;

  morse_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (key_in),
    .level (w_key_db)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_dur   <= '0;
      r_gap   <= '0;
      r_elem  <= '0;
      r_sym   <= SYM_NONE;
      r_ovf   <= 1'b0;
    end else begin
      r_sym <= SYM_NONE;
      case (r_state)
        ST_IDLE: begin
          if (w_key_db) begin
            r_state <= ST_PRESSED;
            r_dur   <= '0;
          end
        end

        ST_PRESSED: begin
          if (w_key_db) begin
            // Saturating at the threshold is enough to classify a dash.
            if (r_dur < C_DASH) r_dur <= r_dur + 1'b1;
          end else begin
            r_state <= ST_GAP;
            r_gap   <= '0;
            if (r_elem >= C_MAX) begin
              r_ovf <= 1'b1;
            end else begin
              r_elem <= r_elem + 1'b1;
              r_sym  <= (r_dur >= C_DASH) ? SYM_DASH : SYM_DOT;
            end
          end
        end

        ST_GAP: begin
          // A new press takes priority over gap expiry in the same cycle.
          if (w_key_db) begin
            r_state <= ST_PRESSED;
            r_dur   <= '0;
          end else if (r_gap >= C_GAP_LAST) begin
            r_state <= ST_IDLE;
            r_sym   <= SYM_SEND;
            r_elem  <= '0;
            r_ovf   <= 1'b0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign inputSignal = r_sym;
  assign key_db      = w_key_db;
  assign busy        = (r_state != ST_IDLE);
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_morse_key_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_key_decoder
//   Directed bench for morse_key_decoder with short timing parameters.
//   A negedge monitor logs every non-zero symbol with its cycle number and the
//   overflow level at that moment; the directed sequence checks that log.
// -----------------------------------------------------------------------------
module tb_morse_key_decoder;

  localparam int DEB  = 4;
  localparam int DASH = 12;
  localparam int GAP  = 30;
  localparam int MAXE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_in;
  logic [1:0] inputSignal;
  logic       key_db;
  logic       busy;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  morse_key_decoder #(
    .DEBOUNCE_CYCLES   (DEB),
    .DASH_MIN_CYCLES   (DASH),
    .LETTER_GAP_CYCLES (GAP),
    .MAX_ELEMS         (MAXE),
    .CNT_W             (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .inputSignal (inputSignal),
    .key_db      (key_db),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] ev_sym[$];
  int         ev_cyc[$];
  logic       ev_ovf[$];
  int         adj_viol = 0;
  logic [1:0] prev_sym = 2'b00;

  always @(negedge clk) begin
    if (inputSignal !== 2'b00) begin
      ev_sym.push_back(inputSignal);
      ev_cyc.push_back(cyc);
      ev_ovf.push_back(overflow);
      if (prev_sym !== 2'b00) adj_viol++;
    end
    prev_sym = inputSignal;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sym_at(input int i);
    return (i < ev_sym.size()) ? ev_sym[i] : 2'bxx;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < ev_cyc.size()) ? ev_cyc[i] : -1000;
  endfunction

  function automatic logic ovf_at(input int i);
    return (i < ev_ovf.size()) ? ev_ovf[i] : 1'bx;
  endfunction

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    key_in = 1'b1;
    cyc_n(n);
    key_in = 1'b0;
  endtask

  task automatic clear_ev();
    ev_sym.delete();
    ev_cyc.delete();
    ev_ovf.delete();
  endtask

  initial begin
    rst_n  = 1'b1;
    key_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sym",  32'(inputSignal), 0);
    chk("rst_db",   32'(key_db),      0);
    chk("rst_busy", 32'(busy),        0);
    chk("rst_ovf",  32'(overflow),    0);
    cyc_n(3);
    rst_n = 1'b1;
    cyc_n(3);

    // 1: single dot, send 30 cycles after the symbol; debounce latency 2+DEB
    clear_ev();
    key_in = 1'b1;
    cyc_n(5);
    chk("t1_db_lat5", 32'(key_db), 0);
    key_in = 1'b0;
    cyc_n(1);
    chk("t1_db_lat6", 32'(key_db), 1);
    cyc_n(39);
    chk("t1_nev",    32'(ev_sym.size()), 2);
    chk("t1_sym0",   32'(sym_at(0)), 32'(2'b01));
    chk("t1_sym1",   32'(sym_at(1)), 32'(2'b11));
    chk("t1_spacing", 32'(cyc_at(1) - cyc_at(0)), 30);
    chk("t1_busy",   32'(busy), 0);

    // 2: dash, dot, send; busy across the whole letter
    clear_ev();
    key_in = 1'b1;
    cyc_n(10);
    chk("t2_busy_press1", 32'(busy), 1);
    cyc_n(10);
    key_in = 1'b0;
    cyc_n(4);
    chk("t2_busy_fall", 32'(busy), 1);
    cyc_n(4);
    press(5);
    cyc_n(20);
    chk("t2_busy_gap", 32'(busy), 1);
    cyc_n(20);
    chk("t2_busy_end", 32'(busy), 0);
    chk("t2_nev",  32'(ev_sym.size()), 3);
    chk("t2_sym0", 32'(sym_at(0)), 32'(2'b10));
    chk("t2_sym1", 32'(sym_at(1)), 32'(2'b01));
    chk("t2_sym2", 32'(sym_at(2)), 32'(2'b11));
    chk("t2_sp01", 32'(cyc_at(1) - cyc_at(0)), 13);
    chk("t2_sp12", 32'(cyc_at(2) - cyc_at(1)), 30);

    // 3: one-cycle glitches never reach key_db
    clear_ev();
    for (int i = 0; i < 3; i++) begin
      key_in = 1'b1;
      cyc_n(1);
      chk("t3_db_hi", 32'(key_db), 0);
      key_in = 1'b0;
      cyc_n(1);
      chk("t3_busy", 32'(busy), 0);
    end
    cyc_n(10);
    chk("t3_db_end",   32'(key_db), 0);
    chk("t3_busy_end", 32'(busy), 0);
    chk("t3_nev",      32'(ev_sym.size()), 0);

    // 4: five dots, fifth suppressed; send clears overflow in the same cycle
    clear_ev();
    for (int i = 0; i < 5; i++) begin
      press(5);
      cyc_n(8);
    end
    chk("t4_ovf_set", 32'(overflow), 1);
    chk("t4_nev_pre", 32'(ev_sym.size()), 4);
    cyc_n(40);
    chk("t4_nev", 32'(ev_sym.size()), 5);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_dot%0d", i), 32'(sym_at(i)), 32'(2'b01));
    chk("t4_send",     32'(sym_at(4)), 32'(2'b11));
    chk("t4_ovf_send", 32'(ovf_at(4)), 0);
    chk("t4_ovf_pre",  32'(ovf_at(3)), 0);
    chk("t4_sp_send",  32'(cyc_at(4) - cyc_at(3)), 43);
    chk("t4_ovf_end",  32'(overflow), 0);

    // 5: dash threshold boundary, dur_cnt 11 vs 12 at release
    clear_ev();
    press(12);
    cyc_n(45);
    press(13);
    cyc_n(45);
    chk("t5_nev",  32'(ev_sym.size()), 4);
    chk("t5_d11",  32'(sym_at(0)), 32'(2'b01));
    chk("t5_s1",   32'(sym_at(1)), 32'(2'b11));
    chk("t5_d12",  32'(sym_at(2)), 32'(2'b10));
    chk("t5_s2",   32'(sym_at(3)), 32'(2'b11));

    // 6: reset mid-GAP discards the letter; next letter starts with elem_cnt=0
    clear_ev();
    press(5);
    cyc_n(15);
    chk("t6_busy_gap", 32'(busy), 1);
    chk("t6_nev_dot",  32'(ev_sym.size()), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sym",  32'(inputSignal), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_ovf",  32'(overflow), 0);
    chk("t6_rst_db",   32'(key_db), 0);
    cyc_n(2);
    rst_n = 1'b1;
    cyc_n(40);
    chk("t6_no_send", 32'(ev_sym.size()), 1);
    clear_ev();
    for (int i = 0; i < 4; i++) begin
      press(5);
      cyc_n(8);
    end
    chk("t6_ovf_fresh", 32'(overflow), 0);
    cyc_n(40);
    chk("t6_nev",  32'(ev_sym.size()), 5);
    chk("t6_dot3", 32'(sym_at(3)), 32'(2'b01));
    chk("t6_send", 32'(sym_at(4)), 32'(2'b11));
    chk("t6_sp",   32'(cyc_at(4) - cyc_at(3)), 30);

    chk("adjacent_pulses", 32'(adj_viol), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
